// File: rtl/uart_wb_host_pkg.sv
// uart_wb_host_pkg
// Shared definitions for the UART-driven Wishbone host: default command
// codes, response codes, FSM state encoding and the default bus watchdog
// limit. The watchdog limit is only consumed when WB_TIMEOUT_EN is defined.

package uart_wb_host_pkg;

  // Command bytes sent by the debug host
  localparam logic [7:0] DEFAULT_CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] DEFAULT_CMD_READ  = 8'h52;  // 'R'

  // Response bytes returned to the debug host
  localparam logic [7:0] RSP_OK      = 8'h4B;        // 'K'
  localparam logic [7:0] RSP_UNKNOWN = 8'h3F;        // '?'
  localparam logic [7:0] RSP_TIMEOUT = 8'h54;        // 'T'

  // Bus watchdog limit in clock cycles
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    S_CMD   = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_BUS   = 3'd3,
    S_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/uart_wb_host_resp.sv
// uart_wb_host_resp
// Response serializer. On load_i it captures a frame of either one byte
// (first_i only) or five bytes (first_i followed by data_i MSB first) and
// presents it byte by byte on txByte_o/txValid_o using a valid/ready
// handshake. done_o flags the edge on which the final byte is accepted.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load_i       start a new frame (only issued while idle)
//   first_i      first response byte
//   long_i       1: five-byte frame, 0: single byte
//   data_i       payload bytes 3..0 for a five-byte frame
//   txByte_o     current byte (registered)
//   txValid_o    current byte valid (registered)
//   txReady_i    transmitter accepts the byte
//   done_o       last byte of the frame is transferred this cycle

module uart_wb_host_resp
  import uart_wb_host_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [7:0]  first_i,
  input  logic        long_i,
  input  logic [31:0] data_i,
  output logic [7:0]  txByte_o,
  output logic        txValid_o,
  input  logic        txReady_i,
  output logic        done_o
);

  logic [7:0]  byte_q;
  logic        valid_q;
  logic [31:0] rest_q;
  logic [2:0]  remain_q;
  logic        fire;

  assign fire      = valid_q & txReady_i;
  assign done_o    = fire & (remain_q == 3'd0);
  assign txByte_o  = byte_q;
  assign txValid_o = valid_q;

  // Byte and valid only move on an accepted transfer, so a stalled
  // transmitter sees a stable byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q   <= 8'h00;
      valid_q  <= 1'b0;
      rest_q   <= 32'h0;
      remain_q <= 3'd0;
    end else if (load_i) begin
      byte_q   <= first_i;
      rest_q   <= data_i;
      remain_q <= long_i ? 3'd4 : 3'd0;
      valid_q  <= 1'b1;
    end else if (fire) begin
      if (remain_q == 3'd0) begin
        valid_q <= 1'b0;
      end else begin
        byte_q   <= rest_q[31:24];
        rest_q   <= {rest_q[23:0], 8'h00};
        remain_q <= remain_q - 3'd1;
      end
    end
  end

endmodule

// File: rtl/uart_wb_host.sv
// uart_wb_host
// Wishbone initiator driven by a UART byte stream. Decodes
//   W A1 A0 D3 D2 D1 D0  -> one write cycle, response 'K'
//   R A1 A0              -> one read cycle,  response 'K' R3 R2 R1 R0
//   anything else        -> response '?', no bus cycle
// Multi-byte fields are MSB first. One classic single cycle per command.
//
// Optional build macro WB_TIMEOUT_EN: adds a bus watchdog; if no ack
// arrives within TIMEOUT_CYCLES cycles the cycle is abandoned and the
// single byte 'T' is returned. Without it the bus waits for ack forever.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rx_byte/rx_valid/rx_ready  command byte stream in
//   tx_byte/tx_valid/tx_ready  response byte stream out
//   adr_o,dat_o,we_o,sel_o,stb_o,cyc_o,ack_i,dat_i  Wishbone initiator

module uart_wb_host
  import uart_wb_host_pkg::*;
#(
  parameter logic [7:0] CMD_WRITE = DEFAULT_CMD_WRITE,
  parameter logic [7:0] CMD_READ  = DEFAULT_CMD_READ
`ifdef WB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] adr_o,
  output logic [31:0] dat_o,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic        stb_o,
  output logic        cyc_o,
  input  logic        ack_i,
  input  logic [31:0] dat_i
);

  state_e      state_q;
  logic [2:0]  byteCnt_q;
  logic        isWrite_q;
  logic [15:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        rxReady_q;
  logic        cyc_q;
  logic        stb_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic        respLoad_q;
  logic [7:0]  respFirst_q;
  logic        respLong_q;
  logic        respDone;
  logic        rxFire;

  assign rxFire   = rx_valid & rxReady_q;
  assign rx_ready = rxReady_q;
  assign adr_o    = addr_q;
  assign dat_o    = wdata_q;
  assign we_o     = we_q;
  assign sel_o    = sel_q;
  assign stb_o    = stb_q;
  assign cyc_o    = cyc_q;

`ifdef WB_TIMEOUT_EN
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

  logic [TimerW-1:0] timer_q;
  logic              timeoutHit;

  // Fires in the last permitted bus cycle, so cyc_o is high for exactly
  // TIMEOUT_CYCLES cycles before being dropped.
  assign timeoutHit = (state_q == S_BUS) && (timer_q == TimerLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (state_q != S_BUS) begin
      timer_q <= '0;
    end else if (!timeoutHit) begin
      timer_q <= timer_q + 1'b1;
    end
  end
`endif

  // Command parser and bus FSM. All outputs are registered here; the
  // response load strobe is registered as well, so the serializer picks up
  // read data one edge after it is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CMD;
      byteCnt_q   <= 3'd0;
      isWrite_q   <= 1'b0;
      addr_q      <= 16'h0;
      wdata_q     <= 32'h0;
      rdata_q     <= 32'h0;
      rxReady_q   <= 1'b1;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      respLoad_q  <= 1'b0;
      respFirst_q <= 8'h00;
      respLong_q  <= 1'b0;
    end else begin
      respLoad_q <= 1'b0;
      case (state_q)
        S_CMD: begin
          if (rxFire) begin
            if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) begin
              isWrite_q <= (rx_byte == CMD_WRITE);
              byteCnt_q <= 3'd0;
              wdata_q   <= 32'h0;
              state_q   <= S_ADDR;
            end else begin
              respFirst_q <= RSP_UNKNOWN;
              respLong_q  <= 1'b0;
              respLoad_q  <= 1'b1;
              rxReady_q   <= 1'b0;
              state_q     <= S_RESP;
            end
          end
        end

        S_ADDR: begin
          if (rxFire) begin
            addr_q <= {addr_q[7:0], rx_byte};
            if (byteCnt_q == 3'd1) begin
              byteCnt_q <= 3'd0;
              if (isWrite_q) begin
                state_q <= S_WDATA;
              end else begin
                rxReady_q <= 1'b0;
                cyc_q     <= 1'b1;
                stb_q     <= 1'b1;
                we_q      <= 1'b0;
                sel_q     <= 4'hF;
                state_q   <= S_BUS;
              end
            end else begin
              byteCnt_q <= byteCnt_q + 3'd1;
            end
          end
        end

        S_WDATA: begin
          if (rxFire) begin
            wdata_q <= {wdata_q[23:0], rx_byte};
            if (byteCnt_q == 3'd3) begin
              byteCnt_q <= 3'd0;
              rxReady_q <= 1'b0;
              cyc_q     <= 1'b1;
              stb_q     <= 1'b1;
              we_q      <= 1'b1;
              sel_q     <= 4'hF;
              state_q   <= S_BUS;
            end else begin
              byteCnt_q <= byteCnt_q + 3'd1;
            end
          end
        end

        S_BUS: begin
          if (ack_i) begin
            if (!isWrite_q) begin
              rdata_q <= dat_i;
            end
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            respFirst_q <= RSP_OK;
            respLong_q  <= ~isWrite_q;
            respLoad_q  <= 1'b1;
            state_q     <= S_RESP;
          end
`ifdef WB_TIMEOUT_EN
          else if (timeoutHit) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            respFirst_q <= RSP_TIMEOUT;
            respLong_q  <= 1'b0;
            respLoad_q  <= 1'b1;
            state_q     <= S_RESP;
          end
`endif
        end

        S_RESP: begin
          if (respDone) begin
            rxReady_q <= 1'b1;
            state_q   <= S_CMD;
          end
        end

        default: begin
          state_q <= S_CMD;
        end
      endcase
    end
  end

  uart_wb_host_resp uResp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (respLoad_q),
    .first_i   (respFirst_q),
    .long_i    (respLong_q),
    .data_i    (rdata_q),
    .txByte_o  (tx_byte),
    .txValid_o (tx_valid),
    .txReady_i (tx_ready),
    .done_o    (respDone)
  );

endmodule

// File: tb/tb_uart_wb_host.sv
// tb_uart_wb_host
// Table-driven bench for uart_wb_host: each record holds a command byte
// stream, the responder behaviour and the expected bus cycle and response
// bytes. Hand-written sequences cover reset in the middle of a bus cycle
// and, when WB_TIMEOUT_EN is defined, the bus watchdog.

module tb_uart_wb_host;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] adr_o;
  logic [31:0] dat_o;
  logic        we_o;
  logic [3:0]  sel_o;
  logic        stb_o;
  logic        cyc_o;
  logic        ack_i;
  logic [31:0] dat_i;

  int errors = 0;
  int checks = 0;

  // Responder model state
  int          ackDelay   = 1;
  logic [31:0] readData   = 32'h0;
  bit          ackEnable  = 1'b1;
  logic        injectAck  = 1'b0;
  int          busCnt     = 0;
  int          busStarts  = 0;
  int          busUnstable = 0;
  int          lastCycLen = 0;
  logic [15:0] seenAdr;
  logic [31:0] seenDat;
  logic        seenWe;
  logic [3:0]  seenSel;

  uart_wb_host #(
    .CMD_WRITE(8'h57),
    .CMD_READ (8'h52)
`ifdef WB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_byte  (tx_byte),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .adr_o    (adr_o),
    .dat_o    (dat_o),
    .we_o     (we_o),
    .sel_o    (sel_o),
    .stb_o    (stb_o),
    .cyc_o    (cyc_o),
    .ack_i    (ack_i),
    .dat_i    (dat_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Wishbone responder: counts cycles with cyc/stb high, records the bus
  // fields on the first one, and raises a one-cycle ack in cycle ackDelay.
  always @(negedge clk) begin
    if (cyc_o && stb_o) begin
      busCnt = busCnt + 1;
      if (busCnt == 1) begin
        busStarts = busStarts + 1;
        seenAdr = adr_o;
        seenDat = dat_o;
        seenWe  = we_o;
        seenSel = sel_o;
      end else if (adr_o !== seenAdr || dat_o !== seenDat ||
                   we_o !== seenWe || sel_o !== seenSel) begin
        busUnstable = busUnstable + 1;
      end
      if (ackEnable && busCnt == ackDelay) begin
        ack_i = 1'b1;
        dat_i = readData;
      end else begin
        ack_i = 1'b0;
      end
    end else begin
      if (busCnt != 0) lastCycLen = busCnt;
      busCnt = 0;
      ack_i  = injectAck;
      dat_i  = 32'h0;
    end
  end

  typedef struct {
    string       name;
    logic [55:0] rx;        // command bytes, first byte in [55:48]
    int          nRx;
    int          ackDelay;
    logic [31:0] rdData;
    logic [3:0]  readyPat;  // tx_ready per cycle, bit 3 first
    bit          expBus;
    logic [15:0] expAdr;
    logic [31:0] expDat;
    bit          chkDat;
    logic        expWe;
    int          nResp;
    logic [39:0] expResp;   // last response byte in [7:0]
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one byte from a negedge and hold it until accepted
  task automatic sendByte(input logic [7:0] b);
    int waited = 0;
    rx_byte  = b;
    rx_valid = 1'b1;
    while (!rx_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!rx_ready) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL rx accept timeout: byte %0h not accepted", b);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Gather response bytes with a repeating tx_ready pattern, checking that
  // stalled bytes hold and that no command byte is accepted meanwhile.
  task automatic collectResp(input string name, input logic [3:0] pat,
                             input int expN, output logic [39:0] got,
                             output int nGot);
    int         k = 0;
    int         stallErr = 0;
    int         rxBusyErr = 0;
    int         extra = 0;
    bit         holding = 1'b0;
    logic [7:0] heldByte = 8'h00;
    got  = 40'h0;
    nGot = 0;
    for (int c = 0; c < 300 && nGot < expN; c++) begin
      tx_ready = pat[3 - (k % 4)];
      k++;
      if (holding && (!tx_valid || tx_byte !== heldByte)) stallErr++;
      holding = 1'b0;
      if (rx_ready) rxBusyErr++;
      if (tx_valid && tx_ready) begin
        got  = {got[31:0], tx_byte};
        nGot = nGot + 1;
      end else if (tx_valid) begin
        holding  = 1'b1;
        heldByte = tx_byte;
      end
      @(negedge clk);
    end
    checkOutput({name, " stall stable"}, stallErr, 0);
    checkOutput({name, " rx blocked"}, rxBusyErr, 0);
    checkOutput({name, " rx_ready after"}, rx_ready, 1'b1);
    tx_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (tx_valid) extra++;
      @(negedge clk);
    end
    checkOutput({name, " no extra tx"}, extra, 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    int          startsBefore;
    logic [55:0] stream;
    logic [39:0] got;
    int          nGot;
    ackDelay     = v.ackDelay;
    readData     = v.rdData;
    ackEnable    = 1'b1;
    startsBefore = busStarts;
    busUnstable  = 0;
    stream       = v.rx;
    for (int i = 0; i < v.nRx; i++) sendByte(stream[55 - 8*i -: 8]);
    collectResp(v.name, v.readyPat, v.nResp, got, nGot);
    checkOutput({v.name, " resp count"}, nGot, v.nResp);
    checkOutput({v.name, " resp bytes"}, got, v.expResp);
    checkOutput({v.name, " bus cycles"}, busStarts - startsBefore,
                v.expBus ? 1 : 0);
    if (v.expBus) begin
      checkOutput({v.name, " adr"}, seenAdr, v.expAdr);
      checkOutput({v.name, " we"}, seenWe, v.expWe);
      checkOutput({v.name, " sel"}, seenSel, 4'hF);
      checkOutput({v.name, " cyc length"}, lastCycLen, v.ackDelay);
      checkOutput({v.name, " bus stable"}, busUnstable, 0);
      if (v.chkDat) checkOutput({v.name, " dat"}, seenDat, v.expDat);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [39:0] got;
    int          nGot;
    int          startsBefore;
    int          waited;
    int          idleTx;

    vecs[0] = '{name:"write", rx:56'h57_0010_DEADBEEF, nRx:7, ackDelay:5,
                rdData:32'h0, readyPat:4'b1111, expBus:1'b1, expAdr:16'h0010,
                expDat:32'hDEADBEEF, chkDat:1'b1, expWe:1'b1, nResp:1,
                expResp:40'h4B};
    vecs[1] = '{name:"read", rx:56'h52_1234_00000000, nRx:3, ackDelay:1,
                rdData:32'hCAFEF00D, readyPat:4'b1111, expBus:1'b1,
                expAdr:16'h1234, expDat:32'h0, chkDat:1'b0, expWe:1'b0,
                nResp:5, expResp:40'h4B_CAFEF00D};
    vecs[2] = '{name:"unknown", rx:56'h41_0000_00000000, nRx:1, ackDelay:1,
                rdData:32'h0, readyPat:4'b1111, expBus:1'b0, expAdr:16'h0,
                expDat:32'h0, chkDat:1'b0, expWe:1'b0, nResp:1,
                expResp:40'h3F};
    vecs[3] = '{name:"read after unknown", rx:56'h52_ABCD_00000000, nRx:3,
                ackDelay:3, rdData:32'h01020304, readyPat:4'b1111,
                expBus:1'b1, expAdr:16'hABCD, expDat:32'h0, chkDat:1'b0,
                expWe:1'b0, nResp:5, expResp:40'h4B_01020304};
    vecs[4] = '{name:"backpressure read", rx:56'h52_0008_00000000, nRx:3,
                ackDelay:2, rdData:32'h89ABCDEF, readyPat:4'b1001,
                expBus:1'b1, expAdr:16'h0008, expDat:32'h0, chkDat:1'b0,
                expWe:1'b0, nResp:5, expResp:40'h4B_89ABCDEF};
    vecs[5] = '{name:"write top", rx:56'h57_FFFF_00000001, nRx:7,
                ackDelay:2, rdData:32'h0, readyPat:4'b1111, expBus:1'b1,
                expAdr:16'hFFFF, expDat:32'h00000001, chkDat:1'b1,
                expWe:1'b1, nResp:1, expResp:40'h4B};

    rst_n    = 1'b0;
    rx_byte  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Values held while reset is asserted
    checkOutput("reset rx_ready", rx_ready, 1'b1);
    checkOutput("reset tx_valid", tx_valid, 1'b0);
    checkOutput("reset tx_byte", tx_byte, 8'h00);
    checkOutput("reset cyc", cyc_o, 1'b0);
    checkOutput("reset stb", stb_o, 1'b0);
    checkOutput("reset we", we_o, 1'b0);
    checkOutput("reset sel", sel_o, 4'h0);
    checkOutput("reset adr", adr_o, 16'h0);
    checkOutput("reset dat", dat_o, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Reset while a read cycle is waiting for ack
    ackEnable = 1'b0;
    sendByte(8'h52);
    sendByte(8'h00);
    sendByte(8'h44);
    waited = 0;
    while (!stb_o && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("midreset stb before", stb_o, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset cyc async", cyc_o, 1'b0);
    checkOutput("midreset stb async", stb_o, 1'b0);
    checkOutput("midreset rx_ready", rx_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus('{name:"read after reset", rx:56'h52_0000_00000000, nRx:3,
                    ackDelay:2, rdData:32'h13579BDF, readyPat:4'b1111,
                    expBus:1'b1, expAdr:16'h0000, expDat:32'h0,
                    chkDat:1'b0, expWe:1'b0, nResp:5,
                    expResp:40'h4B_13579BDF});

`ifdef WB_TIMEOUT_EN
    // No ack: the watchdog abandons the cycle after 16 cycles
    ackEnable    = 1'b0;
    startsBefore = busStarts;
    sendByte(8'h57);
    sendByte(8'h00);
    sendByte(8'h20);
    sendByte(8'h11);
    sendByte(8'h22);
    sendByte(8'h33);
    sendByte(8'h44);
    collectResp("timeout", 4'b1111, 1, got, nGot);
    checkOutput("timeout resp count", nGot, 1);
    checkOutput("timeout resp byte", got, 40'h54);
    checkOutput("timeout cyc length", lastCycLen, 16);
    checkOutput("timeout bus cycles", busStarts - startsBefore, 1);
    // A late ack must not produce any response or bus activity
    idleTx    = 0;
    injectAck = 1'b1;
    repeat (2) @(negedge clk);
    injectAck = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (tx_valid || cyc_o) idleTx++;
      @(negedge clk);
    end
    checkOutput("late ack ignored", idleTx, 0);
    checkOutput("late ack rx_ready", rx_ready, 1'b1);
    ackEnable = 1'b1;
`endif

    applyStimulus(vecs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
